// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared types and widths for the RV32I pipeline slice.
//   XLEN        : datapath width (32)
//   REG_AW      : register-file address width (5)
//   mem_state_t : request/ack controller states (M_IDLE, M_BUSY)
//   ex_mem_t    : contents of the M (EX/MEM) pipeline register
//   mem_wb_t    : contents of the W (MEM/WB) pipeline register
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic              resultsrc;   // 1 = load
        logic              memwrite;    // 1 = store
        logic              regwrite;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu_result;  // ALU result or memory address
        logic [XLEN-1:0]   rd2;         // store data
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } mem_wb_t;

    // An M-stage instruction needs the data memory if it is a load or a store.
    function automatic logic is_mem_op(input ex_mem_t m);
        return m.valid & (m.resultsrc | m.memwrite);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Request/ack handshake for the data memory. The request is held for as long
// as a memory op sits in M; the M register itself is frozen by o_stall, so
// the op (and therefore the request) can only leave M on the ack cycle.
// Ports:
//   clk, arst_n : clock, async active-low reset
//   i_mem_op    : a valid load/store occupies M
//   i_ack       : memory ack (may arrive in the same cycle as the request)
//   o_req       : memory request
//   o_stall     : hold M and earlier stages
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import rv32i_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic i_mem_op,
    input  logic i_ack,
    output logic o_req,
    output logic o_stall
);

    mem_state_t r_state;

    // M_BUSY marks a request that has waited at least one edge for its ack.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= M_IDLE;
        end else begin
            case (r_state)
                M_IDLE:  if (i_mem_op && !i_ack) r_state <= M_BUSY;
                M_BUSY:  if (i_ack)              r_state <= M_IDLE;
                default:                         r_state <= M_IDLE;
            endcase
        end
    end

    // Request is combinational so a zero-wait ack completes without a bubble;
    // after an ack the next op enters M and raises a fresh request.
    assign o_req   = i_mem_op;
    assign o_stall = o_req & ~i_ack;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_reg
// M and W pipeline registers of an RV32I core with a request/ack data-memory
// port. M captures the execute stage unless stalled by an outstanding memory
// access; W loads from M every cycle (a bubble while M is stalled) and drives
// the register-file write port.
// Configuration macro: MEM_WB_FORWARD_EN -- when defined, fwd_m_* presents
// M-stage ALU results and fwd_w_* mirrors the write port; otherwise all
// fwd_* outputs are tied to 0.
// Ports:
//   clk, arst_n                       : clock, async active-low reset
//   valid_e .. Rd2E                   : execute-stage result
//   stall_o                           : hold execute and earlier stages
//   dmem_req/we/addr/wdata/ack/rdata  : data-memory request/ack port
//   addr_3, wd_3, we                  : register-file write port
//   fwd_m_*, fwd_w_*                  : M- and W-stage forwarding
// ADW/DPW must match rv32i_pkg::REG_AW/XLEN (the packed structs use them).
// ---------------------------------------------------------------------------
module mem_wb_stage_reg
    import rv32i_pkg::*;
#(
    parameter int ADW = REG_AW,
    parameter int DPW = XLEN
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           valid_e,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic           regwriteE,
    input  logic [ADW-1:0] RdE,
    input  logic [DPW-1:0] alu_resultE,
    input  logic [DPW-1:0] Rd2E,
    output logic           stall_o,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [DPW-1:0] dmem_wdata,
    input  logic           dmem_ack,
    input  logic [DPW-1:0] dmem_rdata,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           we,
    output logic           fwd_m_valid,
    output logic [ADW-1:0] fwd_m_rd,
    output logic [DPW-1:0] fwd_m_data,
    output logic           fwd_w_valid,
    output logic [ADW-1:0] fwd_w_rd,
    output logic [DPW-1:0] fwd_w_data
);

    ex_mem_t r_m;
    mem_wb_t r_w;
    ex_mem_t w_m_next;
    mem_wb_t w_w_next;
    logic    w_mem_op;
    logic    w_req;
    logic    w_stall;

    // NOTE: every field gets a value on every path, so no latch is inferred.
    always_comb begin
        w_m_next            = '0;
        w_m_next.valid      = valid_e;
        w_m_next.resultsrc  = resultsrcE;
        w_m_next.memwrite   = memwriteE;
        w_m_next.regwrite   = regwriteE;
        w_m_next.rd         = RdE;
        w_m_next.alu_result = alu_resultE;
        w_m_next.rd2        = Rd2E;
    end

    // NOTE: non-blocking assignments keep both pipeline registers sampling
    // the pre-edge values, whatever order the simulator runs the blocks in.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_m <= '0;
        end else if (!w_stall) begin
            r_m <= w_m_next;
        end
    end

    assign w_mem_op = is_mem_op(r_m);

    mem_access_ctrl u_ctrl (
        .clk      (clk),
        .arst_n   (arst_n),
        .i_mem_op (w_mem_op),
        .i_ack    (dmem_ack),
        .o_req    (w_req),
        .o_stall  (w_stall)
    );

    // A stalled M must not advance, so W sees a bubble. Stores never write
    // the register file, whatever regwriteE said.
    always_comb begin
        w_w_next          = '0;
        w_w_next.valid    = r_m.valid & ~w_stall;
        w_w_next.regwrite = r_m.regwrite & ~r_m.memwrite;
        w_w_next.rd       = r_m.rd;
        w_w_next.data     = r_m.resultsrc ? dmem_rdata : r_m.alu_result;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_w <= '0;
        end else begin
            r_w <= w_w_next;
        end
    end

    assign stall_o    = w_stall;
    assign dmem_req   = w_req;
    assign dmem_we    = r_m.memwrite;
    assign dmem_addr  = r_m.alu_result;
    assign dmem_wdata = r_m.rd2;

    assign we     = r_w.valid & r_w.regwrite & (r_w.rd != '0);
    assign addr_3 = r_w.rd;
    assign wd_3   = r_w.data;

`ifdef MEM_WB_FORWARD_EN
    // Only ALU results are known in M; load data arrives too late to forward.
    assign fwd_m_valid = r_m.valid & r_m.regwrite & ~r_m.resultsrc
                       & ~r_m.memwrite & (r_m.rd != '0);
    assign fwd_m_rd    = r_m.rd;
    assign fwd_m_data  = r_m.alu_result;
    assign fwd_w_valid = we;
    assign fwd_w_rd    = addr_3;
    assign fwd_w_data  = wd_3;
`else
    assign fwd_m_valid = 1'b0;
    assign fwd_m_rd    = '0;
    assign fwd_m_data  = '0;
    assign fwd_w_valid = 1'b0;
    assign fwd_w_rd    = '0;
    assign fwd_w_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage_reg
// Directed vector table, hand-written stall/reset sequences, and a random
// instruction stream checked against an in-order transaction model.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage_reg;
    import rv32i_pkg::*;

    localparam int ADW = 5;
    localparam int DPW = 32;

    logic           clk = 1'b0;
    logic           arst_n;
    logic           valid_e, resultsrcE, memwriteE, regwriteE;
    logic [ADW-1:0] RdE;
    logic [DPW-1:0] alu_resultE, Rd2E;
    logic           stall_o, dmem_req, dmem_we, dmem_ack;
    logic [DPW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [ADW-1:0] addr_3;
    logic [DPW-1:0] wd_3;
    logic           we;
    logic           fwd_m_valid, fwd_w_valid;
    logic [ADW-1:0] fwd_m_rd, fwd_w_rd;
    logic [DPW-1:0] fwd_m_data, fwd_w_data;

    int checks = 0;
    int errors = 0;

    mem_wb_stage_reg #(.ADW(ADW), .DPW(DPW)) dut (
        .clk(clk), .arst_n(arst_n), .valid_e(valid_e), .resultsrcE(resultsrcE),
        .memwriteE(memwriteE), .regwriteE(regwriteE), .RdE(RdE),
        .alu_resultE(alu_resultE), .Rd2E(Rd2E), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .addr_3(addr_3), .wd_3(wd_3), .we(we),
        .fwd_m_valid(fwd_m_valid), .fwd_m_rd(fwd_m_rd), .fwd_m_data(fwd_m_data),
        .fwd_w_valid(fwd_w_valid), .fwd_w_rd(fwd_w_rd), .fwd_w_data(fwd_w_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid_e = 1'b0; resultsrcE = 1'b0; memwriteE = 1'b0; regwriteE = 1'b0;
        RdE = '0; alu_resultE = '0; Rd2E = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic drive_instr(input logic rs, input logic mw, input logic rw,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] d2);
        valid_e = 1'b1; resultsrcE = rs; memwriteE = mw; regwriteE = rw;
        RdE = rd; alu_resultE = alu; Rd2E = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: one instruction at a time, zero-wait ack offered.
    typedef struct {
        string       name;
        logic        rs, mw, rw;
        logic [4:0]  rd;
        logic [31:0] alu, d2, rdata;
        logic        exp_req, exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[8];

    // Random-test transaction model.
    typedef struct {
        logic        rs, mw, rw;
        logic [4:0]  rd;
        logic [31:0] alu, d2, data;
    } instr_t;

    instr_t prog[$];
    int     mem_q[$];
    int     wr_q[$];

    initial begin
        drive_idle();
        arst_n = 1'b0;
        #12;
        check("rst_req",     32'(dmem_req),    32'd0);
        check("rst_stall",   32'(stall_o),     32'd0);
        check("rst_we",      32'(we),          32'd0);
        check("rst_addr3",   32'(addr_3),      32'd0);
        check("rst_wd3",     wd_3,             32'd0);
        check("rst_dmem_we", 32'(dmem_we),     32'd0);
        check("rst_daddr",   dmem_addr,        32'd0);
        check("rst_dwdata",  dmem_wdata,       32'd0);
        check("rst_fwd_m",   32'(fwd_m_valid), 32'd0);
        check("rst_fwd_w",   32'(fwd_w_valid), 32'd0);
        check("rst_state",   32'(dut.u_ctrl.r_state), 32'(M_IDLE));
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        //          name         rs  mw  rw  rd   alu            d2     rdata          req we  wd
        vecs[0] = '{"alu_rd5",   0,  0,  1,  5,   32'h0000_1234, 32'h0, 32'h0,          0,  1,  32'h0000_1234};
        vecs[1] = '{"alu_rd0",   0,  0,  1,  0,   32'h0000_0077, 32'h0, 32'h0,          0,  0,  32'h0000_0077};
        vecs[2] = '{"alu_rd3",   0,  0,  1,  3,   32'h0000_CAFE, 32'h0, 32'h0,          0,  1,  32'h0000_CAFE};
        vecs[3] = '{"store",     0,  1,  1,  9,   32'h0000_0040, 32'h55,32'h0,          1,  0,  32'h0000_0040};
        vecs[4] = '{"load0w",    1,  0,  1,  12,  32'h0000_0200, 32'h0, 32'hA5A5_0001,  1,  1,  32'hA5A5_0001};
        vecs[5] = '{"alu_norw",  0,  0,  0,  6,   32'h0000_0066, 32'h0, 32'h0,          0,  0,  32'h0000_0066};
        vecs[6] = '{"load_rd0",  1,  0,  1,  0,   32'h0000_0300, 32'h0, 32'h1357_9BDF,  1,  0,  32'h1357_9BDF};
        vecs[7] = '{"alu_rd7",   0,  0,  1,  7,   32'h0000_0009, 32'h0, 32'h0,          0,  1,  32'h0000_0009};

        for (int i = 0; i < 8; i++) begin
            drive_instr(vecs[i].rs, vecs[i].mw, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].d2);
            tick();
            // Instruction now in M.
            valid_e = 1'b0;
            dmem_ack = 1'b1;
            dmem_rdata = vecs[i].rdata;
            #1;
            check({vecs[i].name, "_req"},   32'(dmem_req), 32'(vecs[i].exp_req));
            check({vecs[i].name, "_stall"}, 32'(stall_o),  32'd0);
            check({vecs[i].name, "_we_m"},  32'(we),       32'd0);
            if (vecs[i].exp_req) begin
                check({vecs[i].name, "_dwe"},   32'(dmem_we), 32'(vecs[i].mw));
                check({vecs[i].name, "_daddr"}, dmem_addr,    vecs[i].alu);
                check({vecs[i].name, "_dwd"},   dmem_wdata,   vecs[i].d2);
            end
`ifdef MEM_WB_FORWARD_EN
            check({vecs[i].name, "_fwdm_v"}, 32'(fwd_m_valid),
                  32'(vecs[i].rw && !vecs[i].rs && !vecs[i].mw && vecs[i].rd != 5'd0));
            if (vecs[i].rw && !vecs[i].rs && !vecs[i].mw && vecs[i].rd != 5'd0) begin
                check({vecs[i].name, "_fwdm_rd"}, 32'(fwd_m_rd), 32'(vecs[i].rd));
                check({vecs[i].name, "_fwdm_d"},  fwd_m_data,    vecs[i].alu);
            end
`else
            check({vecs[i].name, "_fwdm_off"}, {fwd_m_data[29:0], fwd_m_valid, |fwd_m_rd}, 32'd0);
`endif
            tick();
            // Instruction now in W.
            dmem_ack = 1'b0;
            #1;
            check({vecs[i].name, "_we"},    32'(we),     32'(vecs[i].exp_we));
            check({vecs[i].name, "_addr3"}, 32'(addr_3), 32'(vecs[i].rd));
            check({vecs[i].name, "_wd3"},   wd_3,        vecs[i].exp_wd);
`ifdef MEM_WB_FORWARD_EN
            check({vecs[i].name, "_fwdw_v"}, 32'(fwd_w_valid), 32'(vecs[i].exp_we));
            check({vecs[i].name, "_fwdw_d"}, fwd_w_data,       vecs[i].exp_wd);
`else
            check({vecs[i].name, "_fwdw_off"}, {fwd_w_data[29:0], fwd_w_valid, |fwd_w_rd}, 32'd0);
`endif
            tick();
            check({vecs[i].name, "_bubble"}, 32'(we), 32'd0);
        end

        // Load with a three-cycle wait; the following ALU op waits in E.
        drive_instr(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0100, 32'h0);
        tick();
        drive_instr(1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0022, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ldw_stall", 32'(stall_o),  32'd1);
            check("ldw_req",   32'(dmem_req), 32'd1);
            check("ldw_dwe",   32'(dmem_we),  32'd0);
            check("ldw_addr",  dmem_addr,     32'h0000_0100);
            check("ldw_we",    32'(we),       32'd0);
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ldw_ack_stall", 32'(stall_o),  32'd0);
        check("ldw_ack_req",   32'(dmem_req), 32'd1);
        check("ldw_ack_addr",  dmem_addr,     32'h0000_0100);
        tick();
        dmem_ack = 1'b0;
        valid_e = 1'b0;
        check("ldw_wb_we",   32'(we),     32'd1);
        check("ldw_wb_rd",   32'(addr_3), 32'd10);
        check("ldw_wb_data", wd_3,        32'hDEAD_BEEF);
        tick();
        check("ldw_next_we",   32'(we),     32'd1);
        check("ldw_next_rd",   32'(addr_3), 32'd11);
        check("ldw_next_data", wd_3,        32'h0000_0022);
        tick();
        check("ldw_once", 32'(we), 32'd0);

        // Reset while a load is waiting; a late ack must be ignored.
        drive_instr(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0300, 32'h0);
        tick();
        valid_e = 1'b0;
        #1;
        check("rstm_req",   32'(dmem_req), 32'd1);
        tick();
        check("rstm_busy",  32'(dut.u_ctrl.r_state), 32'(M_BUSY));
        #2;
        arst_n = 1'b0;
        #1;
        check("rstm_req_drop", 32'(dmem_req), 32'd0);
        check("rstm_stall",    32'(stall_o),  32'd0);
        check("rstm_daddr",    dmem_addr,     32'd0);
        check("rstm_we",       32'(we),       32'd0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_1111;
        #1;
        check("rstm_late_req",   32'(dmem_req), 32'd0);
        check("rstm_late_stall", 32'(stall_o),  32'd0);
        check("rstm_idle",       32'(dut.u_ctrl.r_state), 32'(M_IDLE));
        tick();
        dmem_ack = 1'b0;
        check("rstm_no_wr1", 32'(we), 32'd0);
        tick();
        check("rstm_no_wr2", 32'(we), 32'd0);

        // Random stream against the in-order transaction model.
        begin
            logic accepted  = 1'b1;
            logic resp_busy = 1'b0;
            int   wait_cnt  = 0;
            for (int cyc = 0; cyc < 700; cyc++) begin
                if (we) begin
                    if (wr_q.size() == 0) begin
                        check("rnd_unexpected_we", 32'(we), 32'd0);
                    end else begin
                        int h;
                        h = wr_q.pop_front();
                        check("rnd_rd", 32'(addr_3), 32'(prog[h].rd));
                        check("rnd_wd", wd_3,        prog[h].data);
                    end
                end
                if (accepted) begin
                    if (cyc < 600 && $urandom_range(0, 3) != 0) begin
                        int kind;
                        kind = $urandom_range(0, 3);
                        drive_instr(kind == 2, kind == 3, $urandom_range(0, 7) != 0,
                                    5'($urandom_range(0, 31)), $urandom, $urandom);
                    end else begin
                        valid_e = 1'b0;
                        memwriteE = 1'($urandom_range(0, 1));
                        alu_resultE = $urandom;
                    end
                end
                if (dmem_req) begin
                    if (!resp_busy) begin
                        resp_busy = 1'b1;
                        wait_cnt = $urandom_range(0, 3);
                    end
                    if (wait_cnt == 0) begin
                        dmem_ack = 1'b1;
                    end else begin
                        dmem_ack = 1'b0;
                        wait_cnt--;
                    end
                end else begin
                    dmem_ack = ($urandom_range(0, 7) == 0);
                end
                dmem_rdata = $urandom;
                #1;
                check("rnd_req",   32'(dmem_req), 32'(mem_q.size() > 0));
                check("rnd_stall", 32'(stall_o),  32'(dmem_req && !dmem_ack));
                if (mem_q.size() > 0) begin
                    check("rnd_dwe",   32'(dmem_we), 32'(prog[mem_q[0]].mw));
                    check("rnd_daddr", dmem_addr,    prog[mem_q[0]].alu);
                    check("rnd_dwd",   dmem_wdata,   prog[mem_q[0]].d2);
                end
                if (dmem_ack && mem_q.size() > 0) begin
                    int h;
                    h = mem_q.pop_front();
                    if (prog[h].rs) prog[h].data = dmem_rdata;
                    resp_busy = 1'b0;
                end
                accepted = !stall_o;
                if (accepted && valid_e) begin
                    instr_t t;
                    t.rs = resultsrcE; t.mw = memwriteE; t.rw = regwriteE;
                    t.rd = RdE; t.alu = alu_resultE; t.d2 = Rd2E; t.data = alu_resultE;
                    prog.push_back(t);
                    if (t.rs || t.mw) mem_q.push_back(prog.size() - 1);
                    if (t.rw && !t.mw && t.rd != 5'd0) wr_q.push_back(prog.size() - 1);
                end
                tick();
            end
            check("rnd_writes_drained", 32'(wr_q.size()),  32'd0);
            check("rnd_mem_drained",    32'(mem_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
